// File: rtl/instruction_fetch_pkg.sv
// Shared IF-stage definitions: reset/bubble constants and the IF/ID entry layout.
package instruction_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam int          IFID_W            = 64;

    typedef struct packed {
        logic [IFID_W/2-1:0] pc;
        logic [IFID_W/2-1:0] instr;
    } ifid_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries; head is visible combinationally.
// Latency: one cycle from push to head; clear wins over push/pop; overflow is asserted, never absorbed.
module instruction_fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  ifid_t                    push_data,
    input  logic                     pop,
    input  logic                     clear,
    output ifid_t                    head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ifid_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    // Request gating upstream reserves a slot before issuing, so this can never fire.
    always_ff @(posedge clk) begin
        if (!reset && !clear && push && !pop) begin
            assert (count < CW'(DEPTH));
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// RV32I IF stage: owns fetch PC, one outstanding imem request, prefetch FIFO, IF/ID registers.
// Latency: first valid instruction 3 cycles after reset release with zero-wait memory, then 1/cycle.
// Backpressure: stall holds IF/ID and stops requests once FIFO + in-flight fill it; IF_PERF_COUNTERS_EN adds counters.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_stall_i,
    input  logic        if_flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] PIP_instr_o,
    output logic [31:0] PIP_pc_o,
    output logic        PIP_valid_o
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_bubbles_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   pending_pc;
    logic          outstanding;
    logic          drop;
    logic [CW-1:0] fifo_count;
    ifid_t         fifo_head;
    ifid_t         push_entry;
    logic          pop;
    logic          push;
    logic          grant;
    logic          bubble;

    assign pop  = !if_stall_i && !if_flush_i && !redirect_i && (fifo_count != '0);
    assign push = imem_rvalid_i && !drop && !redirect_i;

    // Count the in-flight word against FIFO space so a response always has a slot.
    assign imem_req_o = !reset && !redirect_i && (!outstanding || imem_rvalid_i) &&
                        ((32'(fifo_count) + 32'(outstanding) - 32'(pop)) < 32'(FIFO_DEPTH));
    assign imem_addr_o = fetch_pc;
    assign grant       = imem_req_o && imem_gnt_i;
    assign push_entry  = '{pc: pending_pc, instr: imem_rdata_i};

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= word_align(RESET_PC);
            pending_pc  <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else begin
            if (grant) begin
                outstanding <= 1'b1;
                fetch_pc    <= fetch_pc + 32'd4;
                pending_pc  <= fetch_pc;
            end else if (imem_rvalid_i) begin
                outstanding <= 1'b0;
            end

            if (redirect_i) fetch_pc <= word_align(redirect_pc_i);

            if (imem_rvalid_i)                  drop <= 1'b0;
            else if (redirect_i && outstanding) drop <= 1'b1;
        end
    end

    instruction_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (redirect_i),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign bubble = if_flush_i || redirect_i || (!if_stall_i && !pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            PIP_instr_o <= NOP_INSTR;
            PIP_pc_o    <= '0;
            PIP_valid_o <= 1'b0;
        end else if (if_flush_i || redirect_i) begin
            PIP_instr_o <= NOP_INSTR;
            PIP_pc_o    <= '0;
            PIP_valid_o <= 1'b0;
        end else if (if_stall_i) begin
            PIP_instr_o <= PIP_instr_o;
            PIP_pc_o    <= PIP_pc_o;
            PIP_valid_o <= PIP_valid_o;
        end else if (pop) begin
            PIP_instr_o <= fifo_head.instr;
            PIP_pc_o    <= fifo_head.pc;
            PIP_valid_o <= 1'b1;
        end else begin
            PIP_instr_o <= NOP_INSTR;
            PIP_pc_o    <= '0;
            PIP_valid_o <= 1'b0;
        end
    end

`ifdef IF_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_o <= '0;
            perf_bubbles_o <= '0;
        end else begin
            perf_fetched_o <= perf_fetched_o + 32'(push);
            perf_bubbles_o <= perf_bubbles_o + 32'(bubble);
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run against a stream-order model.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_stall;
    logic        if_flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pip_instr;
    logic [31:0] pip_pc;
    logic        pip_valid;

    int checks   = 0;
    int failures = 0;

    // memory model state
    bit          mem_pend = 0;
    logic [31:0] mem_addr = '0;
    int          mem_wait = 0;
    int          delay_min = 0;
    int          delay_max = 0;
    int          gnt_pct   = 100;

    // what happened at the most recent clock edge
    logic        last_fire;
    logic [31:0] last_addr;
    logic        last_viol;
    logic        last_rv;
    logic        last_req;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .if_stall_i    (if_stall),
        .if_flush_i    (if_flush),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .PIP_instr_o   (pip_instr),
        .PIP_pc_o      (pip_pc),
        .PIP_valid_o   (pip_valid)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // One clock: drive memory inputs at negedge, sample the handshake, cross posedge, return at negedge.
    task automatic tick();
        imem_rvalid = mem_pend && (mem_wait == 0);
        imem_rdata  = imem_rvalid ? word_of(mem_addr) : $urandom;
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        #1;
        last_req  = imem_req;
        last_fire = imem_req && imem_gnt;
        last_addr = imem_addr;
        last_rv   = imem_rvalid;
        last_viol = last_fire && mem_pend && !imem_rvalid;
        @(negedge clk);
        if (reset) begin
            mem_pend = 0;
        end else begin
            if (last_rv) mem_pend = 0;
            else if (mem_pend) mem_wait--;
            if (last_fire) begin
                mem_pend = 1;
                mem_addr = last_addr;
                mem_wait = $urandom_range(delay_max, delay_min);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1; if_stall = 0; if_flush = 0; redirect = 0; redirect_pc = '0;
        gnt_pct = 100; delay_min = 0; delay_max = 0;
        repeat (3) tick();
        checks += 4;
        if (pip_instr !== NOP) begin failures++; $display("FAIL reset_instr: got %h want %h", pip_instr, NOP); end
        if (pip_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want 0", pip_pc); end
        if (pip_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", pip_valid); end
        if (last_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", last_req); end
    endtask

    task automatic test_latency();
        reset = 0;
        tick();
        checks += 3;
        if (!(last_fire === 1'b1 && last_addr === 32'h0)) begin
            failures++; $display("FAIL first_req: fire %b addr %h want 1 00000000", last_fire, last_addr);
        end
        if (pip_valid !== 1'b0) begin failures++; $display("FAIL lat_c0_valid: got %b want 0", pip_valid); end
        tick();
        if (pip_valid !== 1'b0) begin failures++; $display("FAIL lat_c1_valid: got %b want 0", pip_valid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (!(pip_valid === 1'b1 && pip_pc === 32'(4 * k) && pip_instr === word_of(32'(4 * k)))) begin
                failures++;
                $display("FAIL stream_%0d: valid %b pc %h instr %h want pc %h", k, pip_valid, pip_pc, pip_instr, 32'(4 * k));
            end
        end
    endtask

    task automatic test_stall();
        if_stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (!(pip_valid === 1'b1 && pip_pc === 32'h8)) begin
                failures++; $display("FAIL stall_hold_%0d: valid %b pc %h want 1 00000008", i, pip_valid, pip_pc);
            end
        end
        checks++;
        if (last_req !== 1'b0) begin failures++; $display("FAIL stall_req_drop: got %b want 0", last_req); end
        if_stall = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (!(pip_valid === 1'b1 && pip_pc === 32'(12 + 4 * i) && pip_instr === word_of(32'(12 + 4 * i)))) begin
                failures++; $display("FAIL stall_resume_%0d: valid %b pc %h want %h", i, pip_valid, pip_pc, 32'(12 + 4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        bit found = 0;
        bit got_fire = 0;
        bit got_valid = 0;
        delay_min = 2; delay_max = 2;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = mem_pend && (mem_wait > 0);
        end
        checks++;
        if (!found) begin failures++; $display("FAIL redir_setup: got no outstanding request want one"); end
        delay_min = 0; delay_max = 0;
        redirect = 1; redirect_pc = 32'h103;
        tick();
        redirect = 0;
        checks += 2;
        if (!(pip_valid === 1'b0 && pip_instr === NOP && pip_pc === 32'h0)) begin
            failures++; $display("FAIL redir_bubble: valid %b instr %h pc %h want 0 00000013 0", pip_valid, pip_instr, pip_pc);
        end
        if (last_req !== 1'b0) begin failures++; $display("FAIL redir_no_req: got %b want 0", last_req); end
        for (int i = 0; i < 12 && !got_valid; i++) begin
            tick();
            if (last_fire && !got_fire) begin
                got_fire = 1;
                checks++;
                if (last_addr !== 32'h100) begin failures++; $display("FAIL redir_addr: got %h want 00000100", last_addr); end
            end
            if (pip_valid) begin
                got_valid = 1;
                checks++;
                if (!(pip_pc === 32'h100 && pip_instr === word_of(32'h100))) begin
                    failures++; $display("FAIL redir_first: pc %h instr %h want 00000100", pip_pc, pip_instr);
                end
            end
        end
        checks++;
        if (!(got_fire && got_valid)) begin failures++; $display("FAIL redir_timeout: fire %b valid %b want 1 1", got_fire, got_valid); end
    endtask

    task automatic test_gnt_low();
        bit got = 0;
        bit got_next = 0;
        gnt_pct = 0;
        redirect = 1; redirect_pc = 32'h20;
        tick();
        redirect = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 2;
            if (!(last_req === 1'b1 && last_addr === 32'h20)) begin
                failures++; $display("FAIL gnt_low_req_%0d: req %b addr %h want 1 00000020", i, last_req, last_addr);
            end
            if (!(pip_valid === 1'b0 && pip_instr === NOP)) begin
                failures++; $display("FAIL gnt_low_pip_%0d: valid %b instr %h want 0 00000013", i, pip_valid, pip_instr);
            end
        end
        gnt_pct = 100;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            got = pip_valid;
        end
        checks++;
        if (!(got && pip_pc === 32'h20 && pip_instr === word_of(32'h20))) begin
            failures++; $display("FAIL gnt_low_deliver: valid %b pc %h want 1 00000020", got, pip_pc);
        end
        for (int i = 0; i < 3 && !got_next; i++) begin
            tick();
            got_next = pip_valid;
        end
        checks++;
        if (!(got_next && pip_pc === 32'h24)) begin
            failures++; $display("FAIL gnt_low_once: valid %b pc %h want 1 00000024", got_next, pip_pc);
        end
    endtask

    task automatic test_flush_stall();
        logic [31:0] p;
        bit got = pip_valid;
        for (int i = 0; i < 6 && !got; i++) begin
            tick();
            got = pip_valid;
        end
        p = pip_pc;
        if_stall = 1; if_flush = 1;
        tick();
        if_stall = 0; if_flush = 0;
        checks++;
        if (!(pip_instr === NOP && pip_valid === 1'b0 && pip_pc === 32'h0)) begin
            failures++; $display("FAIL flush_stall_bubble: instr %h valid %b pc %h want 00000013 0 0", pip_instr, pip_valid, pip_pc);
        end
        got = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            got = pip_valid;
        end
        checks++;
        if (!(got && pip_pc === p + 32'd4 && pip_instr === word_of(p + 32'd4))) begin
            failures++; $display("FAIL flush_keeps_fifo: valid %b pc %h want %h", got, pip_pc, p + 32'd4);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        bit got = 0;
        bit got_fire = 0;
        delay_min = 2; delay_max = 2;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = mem_pend && (mem_wait > 0);
        end
        delay_min = 0; delay_max = 0;
        reset = 1;
        tick();
        checks += 3;
        if (!found) begin failures++; $display("FAIL rst_mid_setup: got no outstanding request want one"); end
        if (!(pip_instr === NOP && pip_pc === 32'h0 && pip_valid === 1'b0)) begin
            failures++; $display("FAIL rst_mid_outputs: instr %h pc %h valid %b", pip_instr, pip_pc, pip_valid);
        end
        if (last_req !== 1'b0) begin failures++; $display("FAIL rst_mid_req: got %b want 0", last_req); end
        reset = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (last_fire && !got_fire) begin
                got_fire = 1;
                checks++;
                if (last_addr !== 32'h0) begin failures++; $display("FAIL rst_mid_addr: got %h want 00000000", last_addr); end
            end
            got = pip_valid;
        end
        checks++;
        if (!(got && pip_pc === 32'h0 && pip_instr === word_of(32'h0))) begin
            failures++; $display("FAIL rst_mid_restart: valid %b pc %h want 1 00000000", got, pip_pc);
        end
    endtask

    // Model: valid instructions form a contiguous +4 stream restarting at each redirect target.
    task automatic test_random();
        logic [31:0] exp_pc = '0;
        logic [31:0] p_instr, p_pc, tgt;
        logic        p_valid, c_stall, c_flush, c_red;
        int          delivered = 0;
        reset = 1; if_stall = 0; if_flush = 0; redirect = 0;
        repeat (2) tick();
        reset = 0; gnt_pct = 70; delay_min = 0; delay_max = 2;
        for (int n = 0; n < 3000; n++) begin
            c_stall = ($urandom_range(99) < 20);
            c_flush = ($urandom_range(99) < 8);
            c_red   = ($urandom_range(99) < 4);
            tgt     = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            if_stall = c_stall; if_flush = c_flush; redirect = c_red; redirect_pc = tgt;
            p_instr = pip_instr; p_pc = pip_pc; p_valid = pip_valid;
            tick();
            checks += 2;
            if (last_viol) begin failures++; $display("FAIL rnd_one_outstanding: cycle %0d second grant with response pending", n); end
            if (c_red || c_flush) begin
                if (!(pip_valid === 1'b0 && pip_instr === NOP && pip_pc === 32'h0)) begin
                    failures++; $display("FAIL rnd_bubble: cycle %0d valid %b instr %h pc %h", n, pip_valid, pip_instr, pip_pc);
                end
            end else if (c_stall) begin
                if (!(pip_valid === p_valid && pip_instr === p_instr && pip_pc === p_pc)) begin
                    failures++; $display("FAIL rnd_hold: cycle %0d pc %h want %h", n, pip_pc, p_pc);
                end
            end else if (pip_valid === 1'b1) begin
                if (!(pip_pc === exp_pc && pip_instr === word_of(exp_pc))) begin
                    failures++; $display("FAIL rnd_stream: cycle %0d pc %h instr %h want pc %h", n, pip_pc, pip_instr, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end else begin
                if (!(pip_valid === 1'b0 && pip_instr === NOP && pip_pc === 32'h0)) begin
                    failures++; $display("FAIL rnd_idle: cycle %0d valid %b instr %h pc %h", n, pip_valid, pip_instr, pip_pc);
                end
            end
            if (c_red) exp_pc = tgt & ~32'h3;
        end
        if_stall = 0; if_flush = 0; redirect = 0;
        checks++;
        if (delivered < 150) begin failures++; $display("FAIL rnd_progress: got %0d want at least 150", delivered); end
    endtask

    initial begin
        reset = 1; if_stall = 0; if_flush = 0; redirect = 0; redirect_pc = '0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_stall();
        test_redirect();
        test_gnt_low();
        test_flush_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
